// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M iterative multiply/divide sequencer:
// FSM states, funct3 op codes and iteration counter sizing.
package muldiv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   localparam int ITER_LAST = 31;
   localparam int CNT_W     = 5;

   // rs1 is interpreted as signed for MULH, MULHSU, DIV and REM
   function automatic logic a_is_signed(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic b_is_signed(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage handshake between the pipeline (master) and the multiply/divide
// sequencer (slave).
interface muldiv_sequencer_if #(parameter int XLEN = 32);

   logic            start_i;
   logic [2:0]      op_i;
   logic [XLEN-1:0] rs1_i;
   logic [XLEN-1:0] rs2_i;
   logic            flush_i;
   logic            stall_o;
   logic            done_o;
   logic [XLEN-1:0] result_o;
   logic            busy_o;

   modport master (
      output start_i, op_i, rs1_i, rs2_i, flush_i,
      input  stall_o, done_o, result_o, busy_o
   );

   modport slave (
      input  start_i, op_i, rs1_i, rs2_i, flush_i,
      output stall_o, done_o, result_o, busy_o
   );

endinterface

// File: rtl/muldiv_iter_step.sv
// One radix-2 iteration: shift-add for multiply (acc is the product high
// half) or restoring subtract for divide (acc is the partial remainder).
module muldiv_iter_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] acc,
   input  logic [XLEN-1:0] operand,
   input  logic            is_div,
   input  logic            bit_in,
   output logic [XLEN-1:0] acc_next,
   output logic            bit_out
);

   logic [XLEN:0]   sum;
   logic [XLEN:0]   shifted;
   logic [XLEN-1:0] rem_sub;
   logic            fits;

   // Multiply: bit_in is the multiplier LSB, bit_out drops into the low half.
   // Divide: bit_in is the next dividend bit, bit_out is the quotient bit.
   always_comb begin
      sum      = {1'b0, acc} + (bit_in ? {1'b0, operand} : '0);
      shifted  = {acc, bit_in};
      fits     = (shifted >= {1'b0, operand});
      rem_sub  = shifted[XLEN-1:0] - operand;
      acc_next = sum[XLEN:1];
      bit_out  = sum[0];
      if (is_div) begin
         acc_next = fits ? rem_sub : shifted[XLEN-1:0];
         bit_out  = fits;
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer that stalls EX while it works.
// Optional MULDIV_FAST_MUL_EN: multiplies use a single-cycle 33x33 multiplier.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int ITER = ITER_LAST + 1
) (
   input logic               clk,
   input logic               rst_n,
   muldiv_sequencer_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITER - 1);
   localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state;
   state_t            state_next;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        op_q;
   logic [XLEN-1:0]   opnd_q;
   logic [XLEN-1:0]   hi_q;
   logic [XLEN-1:0]   lo_q;
   logic [XLEN-1:0]   result_q;
   logic              neg_q;

   logic              accept;
   logic              special;
   logic [XLEN-1:0]   special_res;
   logic              a_neg;
   logic              b_neg;
   logic              neg_in;
   logic [XLEN-1:0]   a_mag;
   logic [XLEN-1:0]   b_mag;
   logic              step_bit_in;
   logic              step_bit_out;
   logic [XLEN-1:0]   step_acc;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   div_sel;
   logic [XLEN-1:0]   fix_res;

`ifdef MULDIV_FAST_MUL_EN
   logic signed [2*XLEN-1:0] fast_a;
   logic signed [2*XLEN-1:0] fast_b;
   logic signed [2*XLEN-1:0] fast_prod;

   assign fast_a    = (2*XLEN)'($signed({a_is_signed(bus.op_i) & bus.rs1_i[XLEN-1], bus.rs1_i}));
   assign fast_b    = (2*XLEN)'($signed({b_is_signed(bus.op_i) & bus.rs2_i[XLEN-1], bus.rs2_i}));
   assign fast_prod = fast_a * fast_b;
`endif

   assign accept = ((state == ST_IDLE) || (state == ST_DONE)) && bus.start_i && !bus.flush_i;

   // Operand magnitudes and the sign the final result must take; REM follows the dividend
   always_comb begin
      a_neg  = a_is_signed(bus.op_i) && bus.rs1_i[XLEN-1];
      b_neg  = b_is_signed(bus.op_i) && bus.rs2_i[XLEN-1];
      a_mag  = a_neg ? -bus.rs1_i : bus.rs1_i;
      b_mag  = b_neg ? -bus.rs2_i : bus.rs2_i;
      neg_in = (bus.op_i == OP_REM) ? a_neg : (a_neg ^ b_neg);
   end

   // Operations whose result is known at acceptance skip the iteration
   always_comb begin
      special     = 1'b0;
      special_res = '0;
      if (bus.op_i[2]) begin
         if (bus.rs2_i == '0) begin
            special     = 1'b1;
            special_res = bus.op_i[1] ? bus.rs1_i : '1;
         end else if (!bus.op_i[0] && (bus.rs1_i == MIN_NEG) && (bus.rs2_i == '1)) begin
            special     = 1'b1;
            special_res = bus.op_i[1] ? '0 : MIN_NEG;
         end
      end
`ifdef MULDIV_FAST_MUL_EN
      else begin
         special     = 1'b1;
         special_res = (bus.op_i == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
      end
`endif
   end

   assign step_bit_in = op_q[2] ? lo_q[XLEN-1] : lo_q[0];

   muldiv_iter_step #(.XLEN(XLEN)) u_step (
      .acc      (hi_q),
      .operand  (opnd_q),
      .is_div   (op_q[2]),
      .bit_in   (step_bit_in),
      .acc_next (step_acc),
      .bit_out  (step_bit_out)
   );

   always_comb begin
      prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
      div_sel  = op_q[1] ? hi_q : lo_q;
      if (op_q[2]) begin
         fix_res = neg_q ? -div_sel : div_sel;
      end else begin
         fix_res = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
      end
   end

   // Divides iterate on the dividend in lo_q, multiplies on the multiplier in lo_q
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt      <= '0;
         op_q     <= '0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         result_q <= '0;
         neg_q    <= 1'b0;
      end else if (accept) begin
         cnt    <= '0;
         op_q   <= bus.op_i;
         hi_q   <= '0;
         neg_q  <= neg_in;
         lo_q   <= bus.op_i[2] ? a_mag : b_mag;
         opnd_q <= bus.op_i[2] ? b_mag : a_mag;
         if (special) begin
            result_q <= special_res;
         end
      end else if (state == ST_CALC) begin
         cnt  <= cnt + 1'b1;
         hi_q <= step_acc;
         lo_q <= op_q[2] ? {lo_q[XLEN-2:0], step_bit_out} : {step_bit_out, lo_q[XLEN-1:1]};
      end else if ((state == ST_FIX) && !bus.flush_i) begin
         result_q <= fix_res;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (bus.flush_i) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  state_next = special ? ST_DONE : ST_CALC;
               end else begin
                  state_next = ST_IDLE;
               end
            end
            ST_CALC: begin
               if (cnt == LAST_STEP) begin
                  state_next = ST_FIX;
               end
            end
            ST_FIX: begin
               state_next = ST_DONE;
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // Stall is dropped in DONE so the instruction leaves EX with its result
   always_comb begin
      bus.stall_o  = ((state == ST_IDLE) && bus.start_i && !bus.flush_i) ||
                     (state == ST_CALC) || (state == ST_FIX);
      bus.done_o   = (state == ST_DONE);
      bus.busy_o   = (state != ST_IDLE);
      bus.result_o = result_q;
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: results, latency, stall
// window, special cases, flush, mid-op reset and back-to-back issue.
module tb_muldiv_sequencer;
   import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 34;
`endif
   localparam int DIV_LAT = 34;
   localparam int BUDGET  = 100;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   compared   = 0;
   int   mismatched = 0;

   always #5 clk = ~clk;

   muldiv_sequencer_if #(.XLEN(32)) bus ();

   muldiv_sequencer #(.XLEN(32), .ITER(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic start, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic flush);
      bus.start_i = start;
      bus.op_i    = op;
      bus.rs1_i   = a;
      bus.rs2_i   = b;
      bus.flush_i = flush;
   endtask

   // Issues one op in the next cycle (cycle 0), holds start until done_o,
   // scrambles the operand inputs after acceptance, and checks the outcome
   task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expected, input int exp_lat);
      int cyc;
      int stalls;
      bit seen;
      @(posedge clk); #1;
      applyStimulus(1'b1, op, a, b, 1'b0);
      #1;
      stalls = bus.stall_o ? 1 : 0;
      cyc    = 0;
      seen   = 1'b0;
      while (!seen && cyc < BUDGET) begin
         @(posedge clk); #1;
         cyc++;
         if (bus.stall_o) stalls++;
         if (bus.done_o) begin
            seen = 1'b1;
            checkOutput({tag, ".result"}, bus.result_o, expected);
            bus.start_i = 1'b0;
         end
         bus.rs1_i = $urandom;
         bus.rs2_i = $urandom;
      end
      checkOutput({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
      checkOutput({tag, ".stall_cycles"}, 32'(stalls), 32'(exp_lat));
      @(posedge clk); #1;
      checkOutput({tag, ".done_after"}, 32'(bus.done_o), 32'd0);
      checkOutput({tag, ".busy_after"}, 32'(bus.busy_o), 32'd0);
   endtask

   initial begin
      int dones;
      int cyc;
      bit seen;

      applyStimulus(1'b0, OP_MUL, 32'd0, 32'd0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset.done", 32'(bus.done_o), 32'd0);
      checkOutput("reset.busy", 32'(bus.busy_o), 32'd0);
      checkOutput("reset.stall", 32'(bus.stall_o), 32'd0);
      checkOutput("reset.result", bus.result_o, 32'd0);
      rst_n = 1'b1;

      runOp("div_neg7_2",    OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT);
      runOp("rem_neg7_2",    OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT);
      runOp("div_7_neg2",    OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
      runOp("rem_7_neg2",    OP_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         DIV_LAT);
      runOp("div_min_2",     OP_DIV,    32'h8000_0000, 32'd2,         32'hC000_0000, DIV_LAT);
      runOp("divu_max_1",    OP_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, DIV_LAT);
      runOp("remu_max_16",   OP_REMU,   32'hFFFF_FFFF, 32'h10,        32'h0000_000F, DIV_LAT);
      runOp("divu_by0",      OP_DIVU,   32'd100,       32'd0,         32'hFFFF_FFFF, 1);
      runOp("remu_by0",      OP_REMU,   32'd100,       32'd0,         32'd100,       1);
      runOp("div_by0",       OP_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1);
      runOp("div_ovf",       OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      runOp("rem_ovf",       OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
      runOp("mulh_min_min",  OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
      runOp("mulhsu_m1_max", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
      runOp("mulhu_max_max", OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
      runOp("mul_3_5",       OP_MUL,    32'd3,         32'd5,         32'd15,        MUL_LAT);
      runOp("mul_neg3_5",    OP_MUL,    32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, MUL_LAT);

      // Flush in cycle 10 while start is still held: flush must win
      @(posedge clk); #1;
      applyStimulus(1'b1, OP_DIVU, 32'd1000, 32'd7, 1'b0);
      dones = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (bus.done_o) dones++;
      end
      bus.flush_i = 1'b1;
      @(posedge clk); #1;
      if (bus.done_o) dones++;
      checkOutput("flush.busy", 32'(bus.busy_o), 32'd0);
      checkOutput("flush.stall", 32'(bus.stall_o), 32'd0);
      checkOutput("flush.no_done", 32'(dones), 32'd0);
      applyStimulus(1'b0, OP_MUL, 32'd0, 32'd0, 1'b0);
      runOp("flush_restart", OP_DIVU, 32'd1000, 32'd7, 32'd142, DIV_LAT);

      // Synchronous reset in cycle 10 of a divide
      @(posedge clk); #1;
      applyStimulus(1'b1, OP_DIVU, 32'd1000, 32'd7, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      bus.start_i = 1'b0;
      @(posedge clk); #1;
      checkOutput("rst_mid.busy", 32'(bus.busy_o), 32'd0);
      checkOutput("rst_mid.done", 32'(bus.done_o), 32'd0);
      checkOutput("rst_mid.stall", 32'(bus.stall_o), 32'd0);
      checkOutput("rst_mid.result", bus.result_o, 32'd0);
      rst_n = 1'b1;
      runOp("rst_restart", OP_REMU, 32'd1000, 32'd7, 32'd6, DIV_LAT);

      // Back-to-back: REMU accepted in the DONE cycle of DIVU
      @(posedge clk); #1;
      applyStimulus(1'b1, OP_DIVU, 32'd10, 32'd3, 1'b0);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < BUDGET) begin
         @(posedge clk); #1;
         cyc++;
         if (bus.done_o) seen = 1'b1;
      end
      checkOutput("b2b.op1_latency", 32'(cyc), 32'd34);
      checkOutput("b2b.op1_result", bus.result_o, 32'd3);
      checkOutput("b2b.done_stall", 32'(bus.stall_o), 32'd0);
      bus.op_i = OP_REMU;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < BUDGET) begin
         @(posedge clk); #1;
         cyc++;
         if (bus.done_o) seen = 1'b1;
      end
      bus.start_i = 1'b0;
      checkOutput("b2b.op2_latency", 32'(cyc), 32'd34);
      checkOutput("b2b.op2_result", bus.result_o, 32'd1);
      @(posedge clk); #1;
      checkOutput("b2b.done_after", 32'(bus.done_o), 32'd0);
      checkOutput("b2b.busy_after", 32'(bus.busy_o), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Sequences a shared iterative multiply/divide datapath for the M-extension of the 5-stage RV32IM pipeline.
- Accepts one operation from the EX stage and stalls the pipeline while it iterates, then presents the result for exactly one cycle.
- Sits beside the ALU in EX.
- Its stall output is ORed with the hazard unit's PC and IF/ID enables by the top level.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, radix-2 iterations per multi-cycle op; must equal XLEN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- start_i  in  1  EX stage holds a valid M-extension instruction
- op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_i  in  32  operand A, already forwarded
- rs2_i  in  32  operand B, already forwarded
- flush_i  in  1  abort the in-flight operation (branch flush or trap)
- stall_o  out  1  freeze PC, IF/ID and ID/EX
- done_o  out  1  result_o valid this cycle
- result_o  out  32  operation result
- busy_o  out  1  state is not IDLE

Behaviour:
- Reset values: state IDLE, counter 0, all internal registers 0; done_o=0, result_o=0, busy_o=0.
- Reset asserted mid-operation returns the block to IDLE on that edge; no done_o is produced.
- States:
  - IDLE: start_i=1 and flush_i=0 latches op_i, rs1_i and rs2_i. A special case goes to DONE; anything else goes to CALC with counter=0.
  - CALC: one shift-add or restoring-subtract step per cycle. Counter increments each cycle; when counter==ITER-1, go to FIX.
  - FIX: apply sign correction (negate quotient/remainder/product per operand signs), select hi/lo half or quotient/remainder, go to DONE.
  - DONE: done_o=1 and result_o valid for exactly one cycle. If start_i=1 and flush_i=0, a new op is accepted (same rules as IDLE); otherwise go to IDLE.
- Special cases resolve in 1 cycle (start in cycle 0, done_o in cycle 1):
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- Latency of a normal op: start_i sampled in cycle 0, CALC in cycles 1..32, FIX in cycle 33, done_o in cycle 34.
- stall_o = (state==IDLE & start_i & ~flush_i) | state==CALC | state==FIX.
  - stall_o is low in DONE so the instruction advances with the result.
  - start_i must stay high while stall_o=1; it is re-sampled only in IDLE/DONE.
- Signedness: MULHSU treats rs1 as signed and rs2 as unsigned. The internal product register is 64 bits. Division uses magnitudes plus sign fix in FIX; REM takes the sign of the dividend.
- Operands are captured only on acceptance; later changes on rs1_i/rs2_i are ignored.
- flush_i=1 in any state forces IDLE on the next edge, with no done_o. flush_i wins over a simultaneous start_i.
- result_o holds its last value outside DONE; only done_o qualifies it.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU use a single-cycle 33x33 signed multiplier registered on acceptance, go straight to DONE, and have latency 1. Divide ops are unchanged.
- Undefined: all multiply ops use the 34-cycle iterative path and no hardware multiplier is inferred.

Decomposition:
- Package muldiv_pkg holds:
  - state encoding constants ST_IDLE, ST_CALC, ST_FIX, ST_DONE (2 bits);
  - funct3 op constants OP_MUL through OP_REMU;
  - ITER_LAST=31 and the counter width (5).
- One sub-module, muldiv_iter_step: purely combinational single iteration. Given {acc, operand, is_div}, it returns the next acc and the quotient/product bit, and is instantiated once inside the CALC datapath.
- The FSM, counter and sign-fix logic stay in muldiv_sequencer.

Test Plan:
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> stall_o high in cycles 0-33; done_o in cycle 34 only; result 0xFFFFFFFD (-3). Repeat with REM -> 0xFFFFFFFF (-1).
- DIVU rs1=100, rs2=0 -> done_o in cycle 1, result 0xFFFFFFFF; REMU same operands -> 100.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF -> done_o in cycle 1, result 0x80000000; REM -> 0.
- MULH rs1=0x80000000, rs2=0x80000000 -> result 0x40000000. MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF. MUL 3*5 -> 15. Latency is 34 without MULDIV_FAST_MUL_EN and 1 with it.
- Start DIVU, assert flush_i in cycle 10 -> busy_o low from cycle 11, no done_o. A new start in cycle 12 completes normally. Repeat with rst_n=0 in cycle 10 -> IDLE, outputs 0.
- Back-to-back: start_i held high through DONE of op1 (DIVU 10/3=3) with new operands for op2 (REMU 10/3) -> op2 accepted in op1's DONE cycle; done_o pulses for op1 (3) and, 34 cycles later, for op2 (1).
